// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths and the dump reader's state encoding.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    SUM,
    FINISH
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks register-file addresses FIRST_REG..LAST_REG through one read port and streams each word out.
// Optional trailing XOR checksum beat is built when REGFILE_DUMP_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, read address parked at 0
// READ   | read port driven with ptr, word captured into the output register
// SEND   | beat presented, waiting for out_ready
// SUM    | checksum beat presented (checksum build only)
// FINISH | one-cycle done pulse, then back to IDLE
import regfile_pkg::*;

module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  output logic      busy,
  output logic      done,
  output reg_addr_t rf_rd_addr,
  input  reg_data_t rf_rd_data,
  output logic      out_valid,
  input  logic      out_ready,
  output reg_data_t out_data,
  output reg_addr_t out_index,
  output logic      out_last
);

  if (FIRST_REG > LAST_REG || FIRST_REG < 0 || LAST_REG >= NUM_REGS) begin : g_bad_range
    $error("regfile_dump_reader: need 0 <= FIRST_REG <= LAST_REG < NUM_REGS");
  end

  localparam reg_addr_t FIRST_A = reg_addr_t'(FIRST_REG);
  localparam reg_addr_t LAST_A  = reg_addr_t'(LAST_REG);

  dump_state_t state;
  reg_addr_t   ptr;
  logic        hs;

  assign hs = out_valid & out_ready;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  reg_data_t acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (state == IDLE && start) begin
      acc <= '0;
    end else if (state == SEND && hs) begin
      acc <= acc ^ out_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= FIRST_A;
      busy       <= 1'b0;
      done       <= 1'b0;
      rf_rd_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr        <= FIRST_A;
            rf_rd_addr <= FIRST_A;
            busy       <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          out_data   <= rf_rd_data;
          out_index  <= ptr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          out_last   <= 1'b0;
`else
          out_last   <= (ptr == LAST_A);
`endif
          out_valid  <= 1'b1;
          rf_rd_addr <= '0;
          state      <= SEND;
        end
        SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            // Compare before incrementing so LAST_REG=31 never wraps ptr to 0.
            if (ptr == LAST_A) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              out_data  <= acc ^ out_data;
              out_index <= '0;
              out_last  <= 1'b1;
              out_valid <= 1'b1;
              state     <= SUM;
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
`endif
            end else begin
              ptr        <= ptr + reg_addr_t'(1);
              rf_rd_addr <= ptr + reg_addr_t'(1);
              state      <= READ;
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        SUM: begin
          if (hs) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= FINISH;
          end
        end
`endif
        FINISH: state <= IDLE;
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: full-range instance plus a 30..31 instance.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf [32];

  logic        start0 = 1'b0, ready0 = 1'b0;
  logic        busy0, done0, valid0, last0;
  logic [4:0]  addr0, idx0;
  logic [31:0] data0, rdata0;
  assign rdata0 = rf[addr0];

  logic        start1 = 1'b0, ready1 = 1'b0;
  logic        busy1, done1, valid1, last1;
  logic [4:0]  addr1, idx1;
  logic [31:0] data1, rdata1;
  assign rdata1 = rf[addr1];

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .rf_rd_addr(addr0), .rf_rd_data(rdata0), .out_valid(valid0), .out_ready(ready0),
    .out_data(data0), .out_index(idx0), .out_last(last0));

  regfile_dump_reader #(.FIRST_REG(30), .LAST_REG(31)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rf_rd_addr(addr1), .rf_rd_data(rdata1), .out_valid(valid1), .out_ready(ready1),
    .out_data(data1), .out_index(idx1), .out_last(last1));

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    string name;
    int    stall_idx;
    int    stall_len;
    bit    rand_ready;
    bit    repulse;
    bit    rand_rf;
    int    exp_latency;
    int    exp_beats;
  } vec_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: every register in range in order, register 0 reads as zero, optional XOR trailer.
  function automatic void build_exp(input int first, input int last);
    logic [31:0] x;
    logic [31:0] d;
    exp_q.delete();
    x = '0;
    for (int i = first; i <= last; i++) begin
      d = (i == 0) ? 32'h0 : rf[i];
      x = x ^ d;
      exp_q.push_back('{idx: 5'(i), data: d, last: (CSUM == 0) && (i == last)});
    end
    if (CSUM != 0) exp_q.push_back('{idx: 5'd0, data: x, last: 1'b1});
  endfunction

  task automatic preload();
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = 32'h100 + i;
  endtask

  task automatic randomize_rf();
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
  endtask

  task automatic run_dump(input string name, input int stall_idx, input int stall_len,
                          input bit rand_ready, input bit repulse, input int exp_lat,
                          input int exp_beats);
    int c, lat, last_hs, done_cnt, done_c, stalled, busy_bad, valid_bad, beats, post_bad;
    bit data_beat;
    build_exp(0, 31);
    lat = -1; last_hs = -1; done_cnt = 0; done_c = -1; stalled = 0;
    busy_bad = 0; valid_bad = 0; beats = 0; post_bad = 0;
    @(negedge clk);
    start0 = 1'b1;
    ready0 = 1'b1;
    c = 0;
    while (c < 400 && done_cnt == 0) begin
      @(negedge clk);
      c++;
      start0 = 1'b0;
      if (done0) begin
        done_cnt++;
        done_c = c;
        if (valid0) valid_bad++;
        if (busy0) busy_bad++;
        if (repulse) start0 = 1'b1;
      end else begin
        if (busy0 !== 1'b1) busy_bad++;
        ready0 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (valid0) begin
          if (lat < 0) lat = c;
          if (repulse && idx0 == 5) start0 = 1'b1;
          data_beat = !(CSUM != 0 && last0);
          if (data_beat && idx0 == 5'(stall_idx) && stalled < stall_len) begin
            ready0 = 1'b0;
            stalled++;
            if (exp_q.size() > 0) begin
              chk({name, "_stall_data"}, data0, exp_q[0].data);
              chk({name, "_stall_index"}, idx0, exp_q[0].idx);
            end
          end
          if (ready0) begin
            beats++;
            last_hs = c;
            if (exp_q.size() == 0) begin
              chk({name, "_extra_beat_count"}, beats, exp_beats);
            end else begin
              chk({name, "_beat"}, {idx0, last0, data0}, {exp_q[0].idx, exp_q[0].last, exp_q[0].data});
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (done0 || busy0 || valid0) post_bad++;
      @(negedge clk);
    end
    chk({name, "_done_seen"}, done_cnt, 1);
    chk({name, "_first_valid_latency"}, lat, exp_lat);
    chk({name, "_beats"}, beats, exp_beats);
    chk({name, "_dropped"}, exp_q.size(), 0);
    chk({name, "_done_after_last_hs"}, done_c, last_hs + 1);
    chk({name, "_busy_window"}, busy_bad, 0);
    chk({name, "_valid_at_done"}, valid_bad, 0);
    chk({name, "_idle_after_done"}, post_bad, 0);
    if (stall_len > 0) chk({name, "_stall_cycles"}, stalled, stall_len);
    if (!rand_ready && stall_len == 0) chk({name, "_throughput"}, last_hs, 2 + 2 * 31 + CSUM);
  endtask

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found, done_seen, addr_bad, beats1;
    vecs[0] = '{"plain", -1, 0, 1'b0, 1'b0, 1'b0, 2, 32 + CSUM};
    vecs[1] = '{"stall7", 7, 5, 1'b0, 1'b0, 1'b0, 2, 32 + CSUM};
    vecs[2] = '{"rand_ready", -1, 0, 1'b1, 1'b0, 1'b1, 2, 32 + CSUM};
    vecs[3] = '{"repulse", -1, 0, 1'b0, 1'b1, 1'b0, 2, 32 + CSUM};
    vecs[4] = '{"stall31", 31, 3, 1'b0, 1'b0, 1'b1, 2, 32 + CSUM};
    vecs[5] = '{"stall0_rand", 0, 2, 1'b1, 1'b0, 1'b1, 2, 32 + CSUM};

    preload();
    #2;
    chk("reset_u0", {busy0, done0, valid0, last0, data0, idx0, addr0}, 64'h0);
    chk("reset_u1", {busy1, done1, valid1, last1, data1, idx1, addr1}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].rand_rf) randomize_rf();
      else preload();
      run_dump(vecs[v].name, vecs[v].stall_idx, vecs[v].stall_len, vecs[v].rand_ready,
               vecs[v].repulse, vecs[v].exp_latency, vecs[v].exp_beats);
    end

    // Asynchronous reset in the middle of a dump.
    preload();
    @(negedge clk);
    start0 = 1'b1;
    ready0 = 1'b1;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (valid0 && idx0 == 5'd12) found = 1;
    end
    chk("mid_reset_reached_idx12", found, 1);
    #1 rst = 1'b0;
    #1 chk("mid_reset_outputs_immediate", {busy0, done0, valid0, last0, data0, idx0, addr0}, 64'h0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || valid0 || busy0) done_seen++;
    end
    chk("mid_reset_no_done", done_seen, 0);
    rst = 1'b1;
    run_dump("after_reset", -1, 0, 1'b0, 1'b0, 2, 32 + CSUM);

    // Narrow range 30..31 on the second instance.
    preload();
    build_exp(30, 31);
    @(negedge clk);
    start1 = 1'b1;
    ready1 = 1'b1;
    done_seen = 0; addr_bad = 0; beats1 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (addr1 != 5'd0 && addr1 < 5'd30) addr_bad++;
      if (done1) done_seen++;
      if (valid1) begin
        beats1++;
        if (exp_q.size() > 0) begin
          chk("narrow_beat", {idx1, last1, data1}, {exp_q[0].idx, exp_q[0].last, exp_q[0].data});
          void'(exp_q.pop_front());
        end
      end
    end
    chk("narrow_beats", beats1, 2 + CSUM);
    chk("narrow_dropped", exp_q.size(), 0);
    chk("narrow_done", done_seen, 1);
    chk("narrow_addr_range", addr_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
